// File: rtl/fifo_sync_ctrl_if.sv
// Valid/ready stream bundle for fifo_sync_ctrl: write side (s_*) and read side (m_*).
// slave = the FIFO controller, master = producer/consumer attached to it.
interface fifo_sync_ctrl_if #(
    parameter int WORD_LENGTH = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [WORD_LENGTH-1:0] s_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [WORD_LENGTH-1:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FWFT FIFO controller driving an external registered-read dual-port RAM.
// Define FIFO_CTRL_LEVEL_EN to add the registered level / almost_full outputs.
module fifo_sync_ctrl #(
    parameter int ADDR_BITS   = 8,
    parameter int WORD_LENGTH = 8
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    parameter int AF_MARGIN   = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    fifo_sync_ctrl_if.slave        bus,
    output logic                   ram_we,
    output logic [ADDR_BITS-1:0]   ram_waddr,
    output logic [WORD_LENGTH-1:0] ram_wdata,
    output logic [ADDR_BITS-1:0]   ram_raddr,
    input  logic [WORD_LENGTH-1:0] ram_rdata
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_BITS:0]     level,
    output logic                   almost_full
`endif
);
    localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic               m_valid_q, m_valid_d;
    logic [ADDR_BITS:0] cnt;
    logic               s_ready;
    logic               push;
    logic               pop;

    always_comb begin
        cnt       = wr_ptr_q - rd_ptr_q;
        s_ready   = (cnt != DEPTH) && !flush;
        push      = bus.s_valid && s_ready;
        pop       = m_valid_q && bus.m_ready && !flush;
        wr_ptr_d  = wr_ptr_q + (ADDR_BITS+1)'(push);
        rd_ptr_d  = flush ? wr_ptr_q : rd_ptr_q + (ADDR_BITS+1)'(pop);
        // Compare against the old write pointer: a fresh word needs one more cycle in the RAM
        m_valid_d = !flush && (wr_ptr_q != rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = ram_rdata;

    assign ram_we    = push;
    assign ram_waddr = wr_ptr_q[ADDR_BITS-1:0];
    assign ram_wdata = bus.s_data;
    assign ram_raddr = rd_ptr_d[ADDR_BITS-1:0];

`ifdef FIFO_CTRL_LEVEL_EN
    localparam logic [ADDR_BITS:0] AF_LVL = DEPTH - (ADDR_BITS+1)'(AF_MARGIN);

    logic [ADDR_BITS:0] level_q, level_d;
    logic               almost_full_q, almost_full_d;

    always_comb begin
        level_d       = wr_ptr_d - rd_ptr_d;
        almost_full_d = (level_d >= AF_LVL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign level       = level_q;
    assign almost_full = almost_full_q;
`endif
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl with a behavioural RAM; a word queue is the reference.
// Optional level/almost_full checks follow FIFO_CTRL_LEVEL_EN.
module tb_fifo_sync_ctrl;
    localparam int AB    = 8;
    localparam int WL    = 8;
    localparam int DEPTH = 1 << AB;
    localparam int AFM   = 4;

    logic clk;
    logic rst;
    logic flush;
    logic          ram_we;
    logic [AB-1:0] ram_waddr;
    logic [WL-1:0] ram_wdata;
    logic [AB-1:0] ram_raddr;
    logic [WL-1:0] ram_rdata;
`ifdef FIFO_CTRL_LEVEL_EN
    logic [AB:0]   level;
    logic          almost_full;
`endif

    fifo_sync_ctrl_if #(.WORD_LENGTH(WL)) bus ();

    fifo_sync_ctrl #(.ADDR_BITS(AB), .WORD_LENGTH(WL)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
`ifdef FIFO_CTRL_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    // Registered-read RAM: same-address read during write returns old data
    logic [WL-1:0] mem [DEPTH];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    string tag = "init";

    logic [WL-1:0] q[$];
    bit mv = 1'b0;
    bit last_push, last_pop;
    logic smp_sr, smp_mv;
    logic [WL-1:0] smp_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h want %0h at %0t", tag, nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, sample at negedge, check model, advance model
    task automatic step(input logic r, input logic f, input logic sv,
                        input logic [WL-1:0] sd, input logic mr, input bit do_chk);
        bit exp_sr;
        int pop_n;
        rst = r;
        flush = f;
        bus.s_valid = sv;
        bus.s_data = sd;
        bus.m_ready = mr;
        @(negedge clk);
        exp_sr = (q.size() != DEPTH) && !f;
        smp_sr = bus.s_ready;
        smp_mv = bus.m_valid;
        smp_data = bus.m_data;
        if (do_chk) begin
            chk("s_ready", {31'b0, smp_sr}, {31'b0, exp_sr});
            chk("m_valid", {31'b0, smp_mv}, {31'b0, mv});
            if (mv) chk("m_data", {24'b0, smp_data}, {24'b0, q[0]});
`ifdef FIFO_CTRL_LEVEL_EN
            chk("level", {23'b0, level}, q.size());
            chk("almost_full", {31'b0, almost_full},
                {31'b0, q.size() >= DEPTH - AFM});
`endif
        end
        last_push = !r && !f && sv && exp_sr;
        last_pop  = !r && !f && mv && mr;
        if (r || f) begin
            q.delete();
            mv = 1'b0;
        end else begin
            pop_n = last_pop ? 1 : 0;
            mv = (q.size() - pop_n) > 0;
            if (last_pop) void'(q.pop_front());
            if (last_push) q.push_back(sd);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic          flush;
        logic          s_valid;
        logic [WL-1:0] s_data;
        logic          m_ready;
        logic          chk;
        logic          exp_s_ready;
        logic          exp_m_valid;
        logic [WL-1:0] exp_m_data;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int sent, recv, cyc;
        logic sv, mr;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

        rst = 1'b1;
        flush = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        #1;

        tag = "table";
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].s_valid, tbl[i].s_data,
                 tbl[i].m_ready, 1'b0);
            if (tbl[i].chk) begin
                chk($sformatf("v%0d_s_ready", i), {31'b0, smp_sr}, {31'b0, tbl[i].exp_s_ready});
                chk($sformatf("v%0d_m_valid", i), {31'b0, smp_mv}, {31'b0, tbl[i].exp_m_valid});
                if (tbl[i].exp_m_valid)
                    chk($sformatf("v%0d_m_data", i), {24'b0, smp_data}, {24'b0, tbl[i].exp_m_data});
            end
        end

        tag = "full";
        step(1, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(i), 0, 1);
        step(0, 0, 1, 8'hEE, 0, 1);
        chk("full_no_ready", {31'b0, smp_sr}, 32'd0);
        step(0, 0, 1, 8'hEE, 1, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        chk("ready_after_pop", {31'b0, smp_sr}, 32'd1);

        tag = "order";
        step(1, 0, 0, 8'h00, 0, 1);
        sent = 0;
        recv = 0;
        cyc = 0;
        while (recv < 300 && cyc < 5000) begin
            sv = (sent < 300) && ($urandom_range(0, 3) != 0);
            mr = 1'($urandom_range(0, 1));
            step(0, 0, sv, 8'(sent), mr, 1);
            if (last_push) sent++;
            if (last_pop) begin
                chk("pop_value", {24'b0, smp_data}, {24'b0, 8'(recv)});
                recv++;
            end
            cyc++;
        end
        chk("words_out", recv, 300);

        tag = "hold";
        step(1, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h31 + 8'(i), 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 8'h40 + 8'(i), 0, 1);
            chk("head_stable", {24'b0, smp_data}, 32'h31);
        end

        tag = "flush";
        step(1, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h50 + 8'(i), 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        step(0, 1, 1, 8'h77, 1, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        chk("post_flush_valid", {31'b0, smp_mv}, 32'd0);
        step(0, 0, 1, 8'h3C, 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00, 1, 1);
        chk("first_pop_valid", {31'b0, smp_mv}, 32'd1);
        chk("first_pop_data", {24'b0, smp_data}, 32'h3C);

        tag = "random";
        for (int i = 0; i < 800; i++) begin
            step(0, ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom), ($urandom_range(0, 2) != 0), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
